change_dispense_controller: RTL
===============================

// Module: change_dispense_controller
// PURPOSE
//  Parametrised timeout and change-return controller for the vending machine.
//  - Tracks user inactivity with a reloadable countdown.
//  - On timeout or an explicit return request, snapshots the credit and dispenses
//    it greedily, one coin per valid/ready handshake, largest denomination first.
//  - Sits between the coin/selection inputs and the coin hopper. Upstream credit
//    logic subtracts o_return_amount on every accepted coin.
// PARAMETERS
//  NUM_COINS    3                      number of coin denominations
//  NUM_ITEMS    4                      number of item-select lines
//  TOTAL_BITS   31                     credit width
//  WAIT_CYCLES  10                     countdown reload value, >=1
//  COIN_VALUES  {32'd1000,32'd500,32'd100}
//               packed 32b/coin; slice [32*i+:32] = value of coin i;
//               strictly ascending in i; must be nonzero
// PORTS
//  clk             in   1            clock
//  reset_n         in   1            synchronous active-low reset
//  i_input_coin    in   NUM_COINS    coin-insert pulses (activity)
//  i_select_item   in   NUM_ITEMS    item-select pulses (activity)
//  i_return_req    in   1            immediate return request (pulse)
//  current_total   in   TOTAL_BITS   current credit from upstream
//  i_return_ready  in   1            hopper accepts presented coin
//  o_return_coin   out  NUM_COINS    one-hot coin presented to hopper
//  o_return_valid  out  1            o_return_coin is valid
//  o_return_amount out  TOTAL_BITS   value of presented coin; 0 when !valid
//  o_remaining     out  TOTAL_BITS   credit not yet dispensed
//  o_busy          out  1            state == DISPENSE
//  o_done          out  1            1-cycle pulse after dispense completes
//  wait_time       out  32           countdown value
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wait_time 0. Reset wins over every other input,
//   including mid-DISPENSE; the snapshot is discarded.
//  Activity = |i_input_coin | |i_select_item, sampled at posedge.
//  States: IDLE, COUNT, DISPENSE. o_done is a registered output, not a state.
//  IDLE:
//   - activity -> wait_time<=WAIT_CYCLES, go COUNT.
//   - i_return_req -> snapshot, go DISPENSE.
//  COUNT:
//   - activity -> reload WAIT_CYCLES. Activity beats timeout in the same cycle.
//   - i_return_req with no activity -> wait_time<=0, snapshot, go DISPENSE.
//   - otherwise, if wait_time>1 -> decrement.
//   - wait_time==1 -> wait_time<=0, snapshot, go DISPENSE.
//  Snapshot: o_remaining<=current_total at the transition edge.
//  DISPENSE:
//   - Select the largest coin i with COIN_VALUES[i] <= o_remaining. This is
//     combinational from registered o_remaining.
//   - If a coin is selected: o_return_valid=1, o_return_coin=1<<i,
//     o_return_amount=COIN_VALUES[i].
//   - Coin held stable while !i_return_ready.
//   - valid&ready at posedge -> o_remaining -= COIN_VALUES[i].
//   - No coin fits (o_remaining < smallest value): valid=0; next edge -> IDLE and
//     o_done=1 for exactly one cycle. o_remaining keeps the undispensable residue
//     until the next snapshot.
//   - Activity and i_return_req are ignored; wait_time holds 0.
//  Widths: compare and subtract at TOTAL_BITS. Coin values are truncated to
//   TOTAL_BITS. Subtraction never underflows by construction.
//  Latency: timeout to first valid coin = 1 cycle. One coin per accepted cycle.
// TESTING
//  1 coin pulse cyc0, total=1600, ready=1 -> wait_time 10..1 over cycles 1-10;
//    DISPENSE at 11; coins 1000,500,100 on cycles 11-13; o_done cycle 15;
//    o_remaining=0.
//  2 activity while wait_time=3 -> wait_time=10 next cycle; no DISPENSE until
//    10 quiet cycles elapse.
//  3 i_return_req, total=1750, ready low 4 cycles -> coin[2] held 4 cycles; then
//    1000,500,100,100; o_remaining=50; o_done pulses once.
//  4 timeout with total=0 -> one DISPENSE cycle with valid=0; then IDLE, o_done=1,
//    no coins.
//  5 reset_n low mid-DISPENSE after 1 coin -> next edge all outputs 0, IDLE;
//    coin insert during DISPENSE has no effect on wait_time.
//  6 NUM_COINS=4, COIN_VALUES={500,100,50,10}, total=670 -> coins 500,100,50,10,10;
//    activity with wait_time==1 -> reload, no DISPENSE.

Source files
------------

// File: rtl/change_dispense_controller.sv
// Inactivity timeout plus greedy change return for the vending machine.
// Snapshots credit on timeout or request, then hands coins to the hopper largest-first.
module change_dispense_controller #(
  parameter int unsigned               NUM_COINS   = 3,
  parameter int unsigned               NUM_ITEMS   = 4,
  parameter int unsigned               TOTAL_BITS  = 31,
  parameter int unsigned               WAIT_CYCLES = 10,
  parameter logic [32*NUM_COINS-1:0]   COIN_VALUES = {32'd1000, 32'd500, 32'd100}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_COINS-1:0]  i_input_coin,
  input  logic [NUM_ITEMS-1:0]  i_select_item,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] current_total,
  input  logic                  i_return_ready,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_return_valid,
  output logic [TOTAL_BITS-1:0] o_return_amount,
  output logic [TOTAL_BITS-1:0] o_remaining,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           wait_time
);

  localparam logic [31:0] WAIT_RELOAD = 32'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DISPENSE
  } state_t;

  state_t                state;
  logic                  activity;
  logic                  sel_found;
  logic [NUM_COINS-1:0]  sel_coin;
  logic [TOTAL_BITS-1:0] sel_amt;
  logic [TOTAL_BITS-1:0] coin_val;

  assign activity = (|i_input_coin) | (|i_select_item);

  // Largest fitting coin; values ascend with index so the last match wins.
  always_comb begin
    sel_found = 1'b0;
    sel_coin  = '0;
    sel_amt   = '0;
    coin_val  = '0;
    for (int unsigned i = 0; i < NUM_COINS; i++) begin
      coin_val = TOTAL_BITS'(COIN_VALUES[32*i +: 32]);
      if (coin_val <= o_remaining) begin
        sel_found   = 1'b1;
        sel_coin    = '0;
        sel_coin[i] = 1'b1;
        sel_amt     = coin_val;
      end
    end
  end

  assign o_busy          = (state == DISPENSE);
  assign o_return_valid  = o_busy && sel_found;
  assign o_return_coin   = o_return_valid ? sel_coin : '0;
  assign o_return_amount = o_return_valid ? sel_amt : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_time   <= '0;
      o_remaining <= '0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (activity) begin
            wait_time <= WAIT_RELOAD;
            state     <= COUNT;
          end else if (i_return_req) begin
            wait_time   <= '0;
            o_remaining <= current_total;
            state       <= DISPENSE;
          end
        end
        COUNT: begin
          // Activity always beats both the request and the timeout.
          if (activity) begin
            wait_time <= WAIT_RELOAD;
          end else if (i_return_req || (wait_time <= 32'd1)) begin
            wait_time   <= '0;
            o_remaining <= current_total;
            state       <= DISPENSE;
          end else begin
            wait_time <= wait_time - 32'd1;
          end
        end
        DISPENSE: begin
          wait_time <= '0;
          if (sel_found) begin
            if (i_return_ready) begin
              o_remaining <= o_remaining - sel_amt;
            end
          end else begin
            // Residue below the smallest coin stays visible until the next snapshot.
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
